// File: rtl/loader_pkg.sv
// Shared types for the boot loader and the 8-bit CPU core: byte type, loader states, default memory depth.
// The optional checksum stage is selected by LOADER_CHECKSUM_EN (see prog_loader).
package loader_pkg;

  localparam int LOADER_MEM_DEPTH = 32;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  function automatic byte_t csum_step(input byte_t acc, input byte_t b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Boot loader: writes a LEN/data[/CSUM] byte frame into CPU memory from address 0, then releases cpu_reset.
// Define LOADER_CHECKSUM_EN to require and verify a trailing XOR checksum byte.
module prog_loader
  import loader_pkg::*;
#(
  parameter int MEM_DEPTH = LOADER_MEM_DEPTH,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [8:0]      MAX_LEN = 9'(MEM_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_wdata_d;
  logic              cpu_reset_d, done_d, error_d;
  logic              beat;
  logic              release_core;
`ifdef LOADER_CHECKSUM_EN
  byte_t             csum_q, csum_d;
`endif

  // Ready depends only on state and load_req so upstream never sees a valid->ready loop.
  assign in_ready = !load_req &&
                    (state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM);
  assign beat     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    if (load_req) begin
      state_d = S_LEN;
      cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else if (beat) begin
      unique case (state_q)
        S_LEN: begin
          if (in_data == 8'd0 || {1'b0, in_data} > MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            len_d   = in_data[ADDR_W:0];
            cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = in_data;
`endif
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = in_data;
          cnt_d       = cnt_q + CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
          csum_d      = csum_step(csum_q, in_data);
          if (cnt_q == len_q - CNT_ONE) state_d = S_CSUM;
`else
          if (cnt_q == len_q - CNT_ONE) state_d = S_RUN;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: state_d = (in_data == csum_q) ? S_RUN : S_ERR;
`endif
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  assign release_core = (state_d == S_RUN);
`else
  // Without a checksum beat the last write lands one cycle after entering S_RUN, so hold the core one more cycle.
  assign release_core = (state_d == S_RUN) && (state_q == S_RUN);
`endif

  assign cpu_reset_d = !release_core;
  assign done_d      = release_core;
  assign error_d     = (state_d == S_ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_LEN;
      cnt_q     <= '0;
      len_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      cpu_reset <= cpu_reset_d;
      done      <= done_d;
      error     <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader; frames carry a CSUM byte only when LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset, load_req, in_valid;
  logic [7:0] in_data;
  logic       in_ready, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset, done, error;

  int vectors     = 0;
  int miscompares = 0;

  logic [12:0] exp_q[$];
  logic [7:0]  buf_d[0:31];

  always #5 clk = ~clk;

  prog_loader dut (
    .clk      (clk),
    .reset    (reset),
    .load_req (load_req),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset),
    .done     (done),
    .error    (error)
  );

  // Every memory write must match the next expected {addr,data}.
  always @(negedge clk) begin : scoreboard
    logic [12:0] e;
    if (mem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          miscompares++;
          $display("FAIL mem_write got addr=%0d data=%h, required addr=%0d data=%h",
                   mem_addr, mem_wdata, e[12:8], e[7:0]);
        end else begin
          $display("write addr=%0d data=%h ok", mem_addr, mem_wdata);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL beat_timeout byte=%h got in_ready=0, required 1", b);
    in_valid = 1'b0;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_during_load_req got %b, required 0", in_ready);
    end
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] len, input int n, input bit gap, input logic [7:0] csum_flip);
    logic [7:0] cs;
    cs = len;
    send(len, gap);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({5'(i), buf_d[i]});
      cs = cs ^ buf_d[i];
      send(buf_d[i], gap);
    end
`ifdef LOADER_CHECKSUM_EN
    send(cs ^ csum_flip, gap);
`else
    cs = cs ^ csum_flip;
`endif
  endtask

  task automatic check_queue_empty(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_pending_writes got %0d left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Called right after the final beat's edge; checks release timing for the active build.
  task automatic check_release(input string name);
`ifndef LOADER_CHECKSUM_EN
    vectors++;
    if (cpu_reset !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_early_release got cpu_reset=%b done=%b, required 1/0", name, cpu_reset, done);
    end
    @(posedge clk); #1;
`endif
    vectors++;
    if (cpu_reset !== 1'b0 || done !== 1'b1 || error !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_release got cpu_reset=%b done=%b error=%b in_ready=%b, required 0/1/0/0",
               name, cpu_reset, done, error, in_ready);
    end else $display("%s released core", name);
  endtask

  task automatic test_reset();
    reset = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #2;
    vectors++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error} !== {1'b1, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values got rdy=%b we=%b a=%0d d=%h rst=%b done=%b err=%b",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error);
    end else $display("reset values ok");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_load3();
    buf_d[0] = 8'h8C; buf_d[1] = 8'hC3; buf_d[2] = 8'h10;
    send_frame(8'd3, 3, 1'b0, 8'h00);
    check_release("load3");
    @(posedge clk); #1;
    check_queue_empty("load3");
  endtask

  task automatic test_bad_csum();
`ifdef LOADER_CHECKSUM_EN
    pulse_load();
    buf_d[0] = 8'h8C; buf_d[1] = 8'hC3; buf_d[2] = 8'h10;
    send_frame(8'd3, 3, 1'b0, 8'h01);
    vectors++;
    if (error !== 1'b1 || cpu_reset !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_csum got error=%b cpu_reset=%b in_ready=%b done=%b, required 1/1/0/0",
               error, cpu_reset, in_ready, done);
    end else $display("bad csum -> error ok");
    pulse_load();
    vectors++;
    if (in_ready !== 1'b1 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_after_error got in_ready=%b error=%b, required 1/0", in_ready, error);
    end
    check_queue_empty("bad_csum");
`else
    pulse_load();
    buf_d[0] = 8'hA5; buf_d[1] = 8'h3C;
    send_frame(8'd2, 2, 1'b0, 8'h00);
    check_release("len2_delay");
    check_queue_empty("len2_delay");
`endif
  endtask

  task automatic test_bad_len(input logic [7:0] len);
    pulse_load();
    send(len, 1'b0);
    vectors++;
    if (error !== 1'b1 || cpu_reset !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_len_%h got error=%b cpu_reset=%b in_ready=%b, required 1/1/0",
               len, error, cpu_reset, in_ready);
    end else $display("LEN %h -> error ok", len);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_full_gap();
    pulse_load();
    for (int i = 0; i < 32; i++) buf_d[i] = 8'($urandom_range(0, 255));
    send_frame(8'd32, 32, 1'b1, 8'h00);
    check_release("full32");
    check_queue_empty("full32");
  endtask

  task automatic test_abort();
    pulse_load();
    buf_d[0] = 8'h11; buf_d[1] = 8'h22;
    send(8'd4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({5'(i), buf_d[i]});
      send(buf_d[i], 1'b0);
    end
    in_valid = 1'b1; in_data = 8'hEE; load_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_ready got %b, required 0", in_ready);
    end
    @(posedge clk); #1;
    load_req = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_we !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_no_write got mem_we=%b in_ready=%b, required 0/1", mem_we, in_ready);
    end else $display("abort beat dropped ok");
    @(posedge clk); #1;
    buf_d[0] = 8'h5A;
    send_frame(8'd1, 1, 1'b0, 8'h00);
    check_release("after_abort");
    check_queue_empty("after_abort");
  endtask

  task automatic test_async_reset();
    pulse_load();
    buf_d[0] = 8'h77; buf_d[1] = 8'h88;
    send(8'd4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({5'(i), buf_d[i]});
      send(buf_d[i], 1'b0);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error} !== {1'b1, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset got rdy=%b we=%b a=%0d d=%h rst=%b done=%b err=%b",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error);
    end else $display("async reset ok");
    @(posedge clk); #1;
    reset = 1'b0;
    check_queue_empty("async_reset");
    buf_d[0] = 8'h01; buf_d[1] = 8'h02; buf_d[2] = 8'h04; buf_d[3] = 8'h08;
    send_frame(8'd4, 4, 1'b0, 8'h00);
    check_release("after_reset");
    check_queue_empty("after_reset");
  endtask

  initial begin
    test_reset();
    test_load3();
    test_bad_csum();
    test_bad_len(8'h00);
    test_bad_len(8'h21);
    test_full_gap();
    test_abort();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
